// File: rtl/pc_gen_multi.sv
// pc_gen_multi: fetch-PC generator with prioritised redirect arbitration,
// stall-time redirect latching and an epoch tag on every fetch request.
module pc_gen_multi #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_ADDR = 64'h8000_0000,
  parameter int              NUM_REDIR  = 4,
  parameter int              EPOCH_W    = 3,
  parameter int              RVC_EN     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
  input  logic                      step_half_i,
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output logic [XLEN-1:0]           req_pc_o,
  output logic [EPOCH_W-1:0]        req_epoch_o,
  output logic [XLEN-1:0]           pc_o,
  output logic                      pend_o
);

  logic [XLEN-1:0]    pc_reg;
  logic [EPOCH_W-1:0] epoch_reg;
  logic               pend_valid_reg;
  logic [XLEN-1:0]    pend_pc_reg;

  logic [XLEN-1:0]    redir_slot [NUM_REDIR];
  logic               live_redir;
  logic [XLEN-1:0]    redir_target;
  logic [XLEN-1:0]    step;
  logic               accept;

  // Split the flat target bus into one word per redirect slot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REDIR; gi++) begin : g_slot
      assign redir_slot[gi] = redir_pc_i[gi*XLEN +: XLEN];
    end
  endgenerate

  // Priority pick: scan from the highest index down so the lowest set slot wins.
  always_comb begin
    redir_target = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        redir_target = redir_slot[k];
      end
    end
  end

  assign live_redir = |redir_valid_i;
  assign step       = ((RVC_EN != 0) && step_half_i) ? XLEN'(2) : XLEN'(4);

  // A pending redirect blocks issue so its bubble cycle is visible downstream.
  assign req_valid_o = ~rst & ~stall_i & ~pend_valid_reg;
  assign accept      = req_valid_o & req_ready_i;

  assign req_pc_o    = pc_reg;
  assign pc_o        = pc_reg;
  assign req_epoch_o = epoch_reg;
  assign pend_o      = pend_valid_reg;

  // PC / epoch / pending-redirect state update, highest-priority case first.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg         <= RESET_ADDR;
      epoch_reg      <= '0;
      pend_valid_reg <= 1'b0;
      pend_pc_reg    <= RESET_ADDR;
    end else if (stall_i) begin
      // Latch the redirect now; the epoch is counted here, not on release.
      if (live_redir) begin
        pend_valid_reg <= 1'b1;
        pend_pc_reg    <= redir_target;
        epoch_reg      <= epoch_reg + 1'b1;
      end
    end else if (live_redir) begin
      // A live redirect supersedes both a pending one and any open request.
      pc_reg         <= redir_target;
      epoch_reg      <= epoch_reg + 1'b1;
      pend_valid_reg <= 1'b0;
    end else if (pend_valid_reg) begin
      pc_reg         <= pend_pc_reg;
      pend_valid_reg <= 1'b0;
    end else if (accept) begin
      pc_reg <= pc_reg + step;
    end
  end

endmodule

// File: tb/tb_pc_gen_multi.sv
// tb_pc_gen_multi: directed test of pc_gen_multi with hand-computed expectations.
module tb_pc_gen_multi;

  localparam int XLEN      = 64;
  localparam int NUM_REDIR = 4;
  localparam int EPOCH_W   = 3;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic                      clk;
  logic                      rst;
  logic                      stall_i;
  logic [NUM_REDIR-1:0]      redir_valid_i;
  logic [NUM_REDIR*XLEN-1:0] redir_pc_i;
  logic                      step_half_i;
  logic                      req_valid_o;
  logic                      req_ready_i;
  logic [XLEN-1:0]           req_pc_o;
  logic [EPOCH_W-1:0]        req_epoch_o;
  logic [XLEN-1:0]           pc_o;
  logic                      pend_o;

  int n_cmp = 0;
  int n_mis = 0;

  pc_gen_multi #(
    .XLEN      (XLEN),
    .RESET_ADDR(RST_PC),
    .NUM_REDIR (NUM_REDIR),
    .EPOCH_W   (EPOCH_W),
    .RVC_EN    (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redir_valid_i(redir_valid_i),
    .redir_pc_i   (redir_pc_i),
    .step_half_i  (step_half_i),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_pc_o     (req_pc_o),
    .req_epoch_o  (req_epoch_o),
    .pc_o         (pc_o),
    .pend_o       (pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_redir(input int k, input logic [63:0] tgt);
    redir_valid_i[k]         = 1'b1;
    redir_pc_i[k*XLEN +: XLEN] = tgt;
  endtask

  task automatic clr_redir();
    redir_valid_i = '0;
    redir_pc_i    = '0;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; step_half_i = 1'b0; req_ready_i = 1'b0;
    clr_redir();

    // Reset state
    tick();
    chk("rst_valid", {63'd0, req_valid_o}, 64'd0);
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_reqpc", req_pc_o, RST_PC);
    chk("rst_epoch", {61'd0, req_epoch_o}, 64'd0);
    chk("rst_pend", {63'd0, pend_o}, 64'd0);

    // Reset release and sequential stream with ready=1
    rst = 1'b0; req_ready_i = 1'b1;
    #1;
    chk("first_valid", {63'd0, req_valid_o}, 64'd1);
    chk("first_pc", req_pc_o, 64'h8000_0000);
    tick();
    chk("stream_pc1", req_pc_o, 64'h8000_0004);
    tick();
    chk("stream_pc2", req_pc_o, 64'h8000_0008);
    chk("stream_epoch", {61'd0, req_epoch_o}, 64'd0);

    // Back-pressure then compressed steps
    rst = 1'b1; tick();
    rst = 1'b0; req_ready_i = 1'b0;
    #1;
    chk("bp_pc0", req_pc_o, 64'h8000_0000);
    chk("bp_valid", {63'd0, req_valid_o}, 64'd1);
    tick();
    chk("bp_pc1", req_pc_o, 64'h8000_0000);
    tick();
    chk("bp_pc2", req_pc_o, 64'h8000_0000);
    req_ready_i = 1'b1; step_half_i = 1'b1;
    tick();
    chk("rvc_pc1", req_pc_o, 64'h8000_0002);
    tick();
    chk("rvc_pc2", req_pc_o, 64'h8000_0004);
    req_ready_i = 1'b0; step_half_i = 1'b0;

    // Simultaneous redirects: slot 0 wins, epoch +1
    set_redir(0, 64'h8000_0100);
    set_redir(2, 64'h8000_0200);
    tick();
    clr_redir();
    chk("prio_pc", req_pc_o, 64'h8000_0100);
    chk("prio_epoch", {61'd0, req_epoch_o}, 64'd1);

    // Redirects during a 4-cycle stall; ready=1 must not advance the PC
    stall_i = 1'b1; req_ready_i = 1'b1;
    #1;
    chk("stall_valid", {63'd0, req_valid_o}, 64'd0);
    set_redir(1, 64'h8000_0040);
    tick();
    clr_redir();
    chk("stall_pend1", {63'd0, pend_o}, 64'd1);
    chk("stall_pc_hold", pc_o, 64'h8000_0100);
    chk("stall_epoch1", {61'd0, req_epoch_o}, 64'd2);
    tick();
    set_redir(3, 64'h8000_0080);
    tick();
    clr_redir();
    chk("stall_epoch2", {61'd0, req_epoch_o}, 64'd3);
    tick();
    chk("stall_pc_hold2", pc_o, 64'h8000_0100);
    stall_i = 1'b0;
    #1;
    chk("bubble_valid", {63'd0, req_valid_o}, 64'd0);
    chk("bubble_pend", {63'd0, pend_o}, 64'd1);
    tick();
    chk("release_pc", req_pc_o, 64'h8000_0080);
    chk("release_valid", {63'd0, req_valid_o}, 64'd1);
    chk("release_pend", {63'd0, pend_o}, 64'd0);
    chk("release_epoch", {61'd0, req_epoch_o}, 64'd3);

    // Epoch wrap: 9 redirects from epoch 0 land on epoch 1; last target near top
    rst = 1'b1; tick();
    rst = 1'b0; req_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_redir(0, (i == 8) ? 64'hFFFF_FFFF_FFFF_FFFC : (64'h8000_1000 + 64'(i * 16)));
      tick();
      clr_redir();
      if (i == 7) chk("wrap_epoch8", {61'd0, req_epoch_o}, 64'd0);
    end
    chk("wrap_epoch9", {61'd0, req_epoch_o}, 64'd1);
    chk("wrap_pc_top", req_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    req_ready_i = 1'b1;
    tick();
    chk("wrap_pc_zero", req_pc_o, 64'h0);
    req_ready_i = 1'b0;

    // Reset while a redirect is pending
    stall_i = 1'b1;
    set_redir(0, 64'h1234_5678);
    tick();
    clr_redir();
    chk("hold_pend", {63'd0, pend_o}, 64'd1);
    rst = 1'b1;
    tick();
    chk("midrst_pend", {63'd0, pend_o}, 64'd0);
    chk("midrst_pc", pc_o, RST_PC);
    chk("midrst_epoch", {61'd0, req_epoch_o}, 64'd0);
    rst = 1'b0; stall_i = 1'b0;
    tick();
    chk("post_rst_pc", req_pc_o, RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pc_gen_multi.md
# pc_gen_multi

Parametrised fetch-PC generator at the front of the fetch pipeline. It arbitrates N prioritised redirect sources (trap, branch, BPU, IDU, …) and holds the fetch PC in a register. It issues that PC to the icache over a valid/ready handshake and steps sequentially by 4, or by 2 for compressed instructions. Two behaviours are new in this generation: redirects that arrive during a stall are latched rather than lost, and every request carries an epoch tag so that downstream logic can discard responses fetched on a stale path.

## Interface
Parameters:
- XLEN, 64, PC width in bits.
- RESET_ADDR, 64'h8000_0000, PC value after reset.
- NUM_REDIR, 4, number of redirect sources. Slot 0 has the highest priority.
- EPOCH_W, 3, epoch tag width.
- RVC_EN, 1, when 1 the 2-byte step is honoured; when 0 the step is always 4.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall_i  in  1  freezes the PC register and suppresses requests.
- redir_valid_i  in  NUM_REDIR  per-slot redirect valid.
- redir_pc_i  in  NUM_REDIR*XLEN  per-slot target. Slot k occupies bits [k*XLEN +: XLEN].
- step_half_i  in  1  the current PC holds a 16-bit instruction, so the next step is 2.
- req_valid_o  out  1  fetch request valid.
- req_ready_i  in  1  icache accepts the request.
- req_pc_o  out  XLEN  fetch address; equals pc_o.
- req_epoch_o  out  EPOCH_W  epoch tag of the request.
- pc_o  out  XLEN  current fetch PC (registered).
- pend_o  out  1  a latched redirect is waiting.

## Operation
- State registers: pc, epoch, pend_valid, pend_pc.
- Modes:
  - RESET: rst high.
  - RUN: pend_valid=0.
  - HOLD: pend_valid=1.
- Live redirect: any redir_valid_i bit set. The winner is the lowest set index; its redir_pc_i slot is the target.
- Step: 2 if RVC_EN=1 and step_half_i=1, otherwise 4. The addition is modulo 2^XLEN, so it wraps silently.
- Accept: req_valid_o & req_ready_i.
- req_valid_o = ~rst & ~stall_i & ~pend_valid.
- Per-cycle update when rst=0, in priority order:
  1. stall_i=1 with a live redirect: pend_valid←1, pend_pc←target, epoch←epoch+1. pc is unchanged. A newer redirect overwrites an older pending one.
  2. stall_i=1 with no live redirect: all state holds.
  3. stall_i=0 with a live redirect: pc←target, epoch←epoch+1, pend_valid←0. Any unaccepted request is abandoned; this is the only case in which req_pc_o may change while req_valid_o=1 without acceptance.
  4. stall_i=0 with pend_valid=1: pc←pend_pc, pend_valid←0. The epoch does not change, because it was already counted when the redirect was latched.
  5. stall_i=0 with accept: pc←pc+step.
  6. Otherwise: hold.
- Epoch increments at most once per cycle regardless of how many slots are valid. It wraps modulo 2^EPOCH_W.
- Redirect inputs are single-cycle pulses. The block does not back-pressure them.

## Timing
- Reset values: pc=RESET_ADDR, epoch=0, pend_valid=0, req_valid_o=0, pend_o=0, req_pc_o=pc_o=RESET_ADDR, req_epoch_o=0.
- First cycle after rst falls: req_valid_o=1, req_pc_o=RESET_ADDR (stall_i=0 assumed).
- If rst is asserted mid-operation, it discards any pending redirect and returns all state to its reset values on the next edge.
- Redirect latency: redirect at cycle N with stall_i=0 gives req_pc_o=target and the new epoch at N+1.
- Stall release: a redirect latched during a stall produces one bubble cycle (req_valid_o=0, pend_o=1) in the first cycle with stall_i=0. The target is issued in the cycle after that.
- Sequential latency: accept at N gives req_pc_o=pc+step at N+1. Back-to-back accepts are sustained, one per cycle.
- req_pc_o and req_epoch_o are stable while req_valid_o=1 and req_ready_i=0, unless a live redirect occurs.
- All outputs are registered or are a simple AND of registered state with stall_i/rst. There is no combinational path from redir_* to req_pc_o.

## Test plan
- Reset and stream: release rst, hold ready=1, step_half_i=0 → req_pc_o reads 0x8000_0000, 0x8000_0004, 0x8000_0008; epoch stays 0.
- Back-pressure and RVC: ready=0 for 3 cycles, then ready=1 with step_half_i=1 → req_pc_o is held at 0x8000_0000 during the stall, then steps to 0x8000_0002, then 0x8000_0004.
- Simultaneous redirects: slot 0 = 0x8000_0100 and slot 2 = 0x8000_0200 in the same cycle → next req_pc_o=0x8000_0100 and epoch increments by exactly 1.
- Redirect during stall: stall_i=1 for 4 cycles with slot 1 = 0x8000_0040, then slot 3 = 0x8000_0080; release the stall → one bubble with pend_o=1, then req_pc_o=0x8000_0080; epoch has increased by 2.
- Wrap: drive 2^EPOCH_W+1 redirects → epoch returns to 1. Redirect to 2^XLEN−4 with one accept → req_pc_o=0.
- Reset mid-HOLD: assert rst while pend_o=1 → on the next cycle pend_o=0, pc_o=RESET_ADDR, epoch=0.
